// File: rtl/control_multiciclo.sv
// Multicycle control FSM: fetch/decode/execute/mem/writeback with halt and sticky traps; 4-5 cycle instruction latency.
// Memory backpressure via mem_ready_i stretches MEM by one cycle per low cycle, trapping after TIMEOUT_CYCLES waits.
module control_multiciclo #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [6:0]  opcode_i,
    input  logic        mem_ready_i,
    input  logic        halt_i,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        regwrite_o,
    output logic        alusrc_o,
    output logic        memread_o,
    output logic        memwrite_o,
    output logic        memtoreg_o,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic [31:0] instret_o
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_TRAP    = 3'd6,
        S_BAD     = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CLS_R     = 2'd0,
        CLS_I     = 2'd1,
        CLS_LOAD  = 2'd2,
        CLS_STORE = 2'd3
    } class_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    class_e      class_q, class_d;
    class_e      op_class;
    logic        op_legal;
    logic [7:0]  wait_q, wait_d;
    logic        illegal_q, timeout_q;
    logic        set_illegal, set_timeout;
    logic [31:0] instret_q;

    logic ir_we, pc_we, regwrite, alusrc, memread, memwrite, memtoreg;

    always_comb begin
        op_legal = 1'b1;
        op_class = CLS_R;
        case (opcode_i)
            7'b0110011: op_class = CLS_R;
            7'b0010011: op_class = CLS_I;
            7'b0000011: op_class = CLS_LOAD;
            7'b0100011: op_class = CLS_STORE;
            default:    op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        wait_d      = wait_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        regwrite    = 1'b0;
        alusrc      = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (halt_i) begin
                    state_d = S_HALT;
                end else begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    class_d = op_class;
                    state_d = S_EXECUTE;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_EXECUTE: begin
                alusrc = (class_q != CLS_R);
                if (class_q == CLS_LOAD || class_q == CLS_STORE) begin
                    wait_d  = 8'd0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alusrc   = 1'b1;
                memread  = (class_q == CLS_LOAD);
                memwrite = (class_q == CLS_STORE);
                // A ready on the final allowed wait cycle still completes normally.
                if (mem_ready_i) begin
                    if (class_q == CLS_STORE) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) begin
                        set_timeout = 1'b1;
                        state_d     = S_TRAP;
                    end
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                memtoreg = (class_q == CLS_LOAD);
                pc_we    = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                if (!halt_i) begin
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                set_illegal = 1'b1;
                state_d     = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_FETCH;
            class_q   <= CLS_R;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
            if (pc_we) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Reset forces FETCH, so enables are masked to keep ir_we_o low while held in reset.
    assign ir_we_o    = ir_we & rst_ni;
    assign pc_we_o    = pc_we & rst_ni;
    assign regwrite_o = regwrite & rst_ni;
    assign alusrc_o   = alusrc & rst_ni;
    assign memread_o  = memread & rst_ni;
    assign memwrite_o = memwrite & rst_ni;
    assign memtoreg_o = memtoreg & rst_ni;
    assign state_o    = state_q;
    assign illegal_o  = illegal_q;
    assign timeout_o  = timeout_q;
    assign instret_o  = instret_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// Randomized bench: an instruction-level plan is expanded into expected per-cycle outputs and compared with the DUT.
// Inputs not consulted in a given phase are randomized to show they are ignored.
module tb_control_multiciclo;

    localparam int T = 15;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_DEC   = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;
    localparam logic [2:0] ST_TRAP  = 3'd6;

    // enable vector: {ir_we, pc_we, regwrite, alusrc, memread, memwrite, memtoreg}
    localparam logic [6:0] EN_IR  = 7'b1000000;
    localparam logic [6:0] EN_PC  = 7'b0100000;
    localparam logic [6:0] EN_REG = 7'b0010000;
    localparam logic [6:0] EN_ALU = 7'b0001000;
    localparam logic [6:0] EN_RD  = 7'b0000100;
    localparam logic [6:0] EN_WR  = 7'b0000010;
    localparam logic [6:0] EN_M2R = 7'b0000001;

    logic        clk_i;
    logic        rst_ni;
    logic [6:0]  opcode_i;
    logic        mem_ready_i;
    logic        halt_i;
    logic        ir_we_o, pc_we_o, regwrite_o, alusrc_o, memread_o, memwrite_o, memtoreg_o;
    logic [2:0]  state_o;
    logic        illegal_o, timeout_o;
    logic [31:0] instret_o;

    control_multiciclo #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .opcode_i    (opcode_i),
        .mem_ready_i (mem_ready_i),
        .halt_i      (halt_i),
        .ir_we_o     (ir_we_o),
        .pc_we_o     (pc_we_o),
        .regwrite_o  (regwrite_o),
        .alusrc_o    (alusrc_o),
        .memread_o   (memread_o),
        .memwrite_o  (memwrite_o),
        .memtoreg_o  (memtoreg_o),
        .state_o     (state_o),
        .illegal_o   (illegal_o),
        .timeout_o   (timeout_o),
        .instret_o   (instret_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       rdy;
        logic       hlt;
        logic [2:0] st;
        logic [6:0] en;
        logic       ill;
        logic       tmo;
    } rec_t;

    rec_t plan[$];
    logic g_ill, g_tmo;
    int   n_checks, n_errors, cyc;
    logic [31:0] m_instret;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic add_rec(input logic rst, input logic [6:0] op, input logic rdy, input logic hlt,
                           input logic [2:0] st, input logic [6:0] en);
        rec_t r;
        r.rst = rst; r.op = op; r.rdy = rdy; r.hlt = hlt;
        r.st = st; r.en = en; r.ill = g_ill; r.tmo = g_tmo;
        plan.push_back(r);
    endtask

    task automatic gen_reset(input int n);
        g_ill = 1'b0;
        g_tmo = 1'b0;
        repeat (n) add_rec(1'b1, rop(), rb(), rb(), ST_FETCH, 7'd0);
    endtask

    task automatic gen_trap();
        repeat (20) add_rec(1'b0, rop(), rb(), rb(), ST_TRAP, 7'd0);
        gen_reset(int'($urandom_range(1, 2)));
    endtask

    task automatic gen_halt(input int k);
        add_rec(1'b0, rop(), rb(), 1'b1, ST_FETCH, 7'd0);
        repeat (k) add_rec(1'b0, rop(), rb(), 1'b1, ST_HALT, 7'd0);
        add_rec(1'b0, rop(), rb(), 1'b0, ST_HALT, 7'd0);
    endtask

    task automatic gen_instr(input logic [6:0] op, input int waits, input bit abort);
        bit isr, isld, isst, legal;
        logic [6:0] men;
        isr   = (op == OP_R);
        isld  = (op == OP_LD);
        isst  = (op == OP_ST);
        legal = isr || isld || isst || (op == OP_I);
        add_rec(1'b0, rop(), rb(), 1'b0, ST_FETCH, EN_IR);
        add_rec(1'b0, op, rb(), rb(), ST_DEC, 7'd0);
        if (!legal) begin
            g_ill = 1'b1;
            gen_trap();
            return;
        end
        add_rec(1'b0, rop(), rb(), rb(), ST_EXEC, isr ? 7'd0 : EN_ALU);
        if (!(isld || isst)) begin
            add_rec(1'b0, rop(), rb(), rb(), ST_WB, EN_PC | EN_REG);
            return;
        end
        men = EN_ALU | (isld ? EN_RD : EN_WR);
        if (abort) begin
            repeat (waits) add_rec(1'b0, rop(), 1'b0, rb(), ST_MEM, men);
            gen_reset(1);
            return;
        end
        if (waits >= T) begin
            repeat (T) add_rec(1'b0, rop(), 1'b0, rb(), ST_MEM, men);
            g_tmo = 1'b1;
            gen_trap();
            return;
        end
        repeat (waits) add_rec(1'b0, rop(), 1'b0, rb(), ST_MEM, men);
        add_rec(1'b0, rop(), 1'b1, rb(), ST_MEM, men | (isst ? EN_PC : 7'd0));
        if (isld) add_rec(1'b0, rop(), rb(), rb(), ST_WB, EN_PC | EN_REG | EN_M2R);
    endtask

    function automatic logic [6:0] pick_legal();
        case ($urandom_range(0, 3))
            0:       return OP_R;
            1:       return OP_I;
            2:       return OP_LD;
            default: return OP_ST;
        endcase
    endfunction

    initial begin
        rec_t r;
        logic [6:0] op;
        int p;
        rst_ni = 1'b0; opcode_i = 7'd0; mem_ready_i = 1'b0; halt_i = 1'b0;
        n_checks = 0; n_errors = 0; cyc = 0; m_instret = 32'd0;
        g_ill = 1'b0; g_tmo = 1'b0;

        gen_reset(2);
        gen_instr(OP_R, 0, 1'b0);
        gen_instr(OP_LD, 3, 1'b0);
        gen_instr(OP_ST, 0, 1'b0);
        gen_instr(7'b1111111, 0, 1'b0);
        gen_instr(OP_LD, T, 1'b0);
        gen_instr(OP_LD, T - 1, 1'b0);
        gen_instr(OP_I, 0, 1'b0);
        gen_halt(3);
        gen_instr(OP_LD, 2, 1'b1);

        for (int i = 0; i < 150; i++) begin
            p = int'($urandom_range(0, 99));
            if (p < 8) begin
                gen_halt(int'($urandom_range(0, 3)));
            end else if (p < 12) begin
                op = rop();
                if (op == OP_R || op == OP_I || op == OP_LD || op == OP_ST) op = 7'b1111111;
                gen_instr(op, 0, 1'b0);
            end else if (p < 15) begin
                gen_instr($urandom_range(0, 1) != 0 ? OP_LD : OP_ST, T + int'($urandom_range(0, 2)), 1'b0);
            end else if (p < 19) begin
                gen_instr($urandom_range(0, 1) != 0 ? OP_LD : OP_ST, int'($urandom_range(0, 5)), 1'b1);
            end else begin
                gen_instr(pick_legal(), ($urandom_range(0, 9) == 0) ? T - 1 : int'($urandom_range(0, 4)), 1'b0);
            end
        end

        while (plan.size() > 0) begin
            r = plan.pop_front();
            @(negedge clk_i);
            rst_ni      = ~r.rst;
            opcode_i    = r.op;
            mem_ready_i = r.rdy;
            halt_i      = r.hlt;
            #1;
            if (r.rst) m_instret = 32'd0;
            check("state", 32'(state_o), 32'(r.st));
            check("enables", 32'({ir_we_o, pc_we_o, regwrite_o, alusrc_o, memread_o, memwrite_o, memtoreg_o}), 32'(r.en));
            check("trap_flags", 32'({illegal_o, timeout_o}), 32'({r.ill, r.tmo}));
            check("instret", instret_o, m_instret);
            check("rw_exclusive", 32'(regwrite_o & memwrite_o), 32'd0);
            if (!r.rst && r.en[5]) m_instret = m_instret + 32'd1;
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
